tmds_encoder_8b10b: RTL and testbench



---
 rtl/tmds_encoder_8b10b.sv | 66 ++++++
 tb/tb_tmds_encoder_8b10b.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_8b10b.sv
// tmds_encoder_8b10b: three-stage DVI TMDS channel encoder, 8-bit pixel or 2-bit control to a DC-balanced 10-bit symbol
module tmds_encoder_8b10b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    output logic [9:0] dout
);
    logic [7:0] d_s1;
    logic [3:0] n1d, n1q;
    logic [1:0] c_s1, c_s2;
    logic de_s1, de_s2, use_xnor;
    logic [8:0] q_m, q_s2;
    logic signed [4:0] cnt, diff, two_q8, two_nq8, nxt;
    logic bal, inv;
    logic [9:0] sym, tok;
    always_comb begin
        use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !d_s1[0]);
        q_m = '0;
        q_m[0] = d_s1[0];
        for (int i = 1; i < 8; i++) q_m[i] = q_m[i-1] ^ d_s1[i] ^ use_xnor;
        q_m[8] = !use_xnor;
    end
    // diff = n1q - n0q; 5-bit wraparound stays exact because |cnt| never exceeds 10
    always_comb begin
        diff = $signed({n1q, 1'b0}) - 5'sd8;
        two_q8 = $signed({3'b0, q_s2[8], 1'b0});
        two_nq8 = $signed({3'b0, !q_s2[8], 1'b0});
        bal = cnt == 5'sd0 || diff == 5'sd0;
        inv = (!cnt[4] && cnt != 5'sd0 && diff > 5'sd0) || (cnt[4] && diff < 5'sd0);
        sym = bal ? {!q_s2[8], q_s2[8], q_s2[8] ? q_s2[7:0] : ~q_s2[7:0]}
                  : {inv, q_s2[8], inv ? ~q_s2[7:0] : q_s2[7:0]};
        nxt = bal ? (q_s2[8] ? cnt + diff : cnt - diff)
                  : (inv ? cnt + two_q8 - diff : cnt + diff - two_nq8);
        tok = c_s2 == 2'b00 ? 10'b1101010100 :
              c_s2 == 2'b01 ? 10'b0010101011 :
              c_s2 == 2'b10 ? 10'b0101010100 : 10'b1010101011;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_s1 <= '0;
            de_s1 <= 1'b0;
            c_s1 <= '0;
            n1d <= '0;
            q_s2 <= '0;
            n1q <= '0;
            de_s2 <= 1'b0;
            c_s2 <= '0;
            cnt <= '0;
            dout <= '0;
        end else begin
            d_s1 <= din;
            de_s1 <= de;
            c_s1 <= {c1, c0};
            n1d <= 4'($countones(din));
            q_s2 <= q_m;
            n1q <= 4'($countones(q_m[7:0]));
            de_s2 <= de_s1;
            c_s2 <= c_s1;
            cnt <= de_s2 ? nxt : 5'sd0;
            dout <= de_s2 ? sym : tok;
        end
    end
endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// tb_tmds_encoder_8b10b: scoreboard bench, directed vectors plus a reference-model random run
module tb_tmds_encoder_8b10b;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de = 1'b0;
    logic [7:0] din = '0;
    logic       c0 = 1'b0;
    logic       c1 = 1'b0;
    logic [9:0] dout;

    typedef struct {
        int         due;
        logic [9:0] exp;
        int         id;
    } ent_t;

    ent_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   vid = 0;
    int   mcnt = 0;

    tmds_encoder_8b10b dut (
        .clk  (clk),
        .rst_n(rst_n),
        .de   (de),
        .din  (din),
        .c0   (c0),
        .c1   (c1),
        .dout (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] tmds_ref(input logic d_e, input logic [7:0] d,
                                            input logic [1:0] c, input int cnt_in,
                                            output int cnt_out);
        int n1, nq1, nq0;
        logic [8:0] q;
        logic [9:0] r;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(d[i]);
        q = '0;
        q[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
            q[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
            q[8] = 1'b1;
        end
        nq1 = 0;
        for (int i = 0; i < 8; i++) nq1 += int'(q[i]);
        nq0 = 8 - nq1;
        if (!d_e) begin
            cnt_out = 0;
            case (c)
                2'b00:   r = 10'b1101010100;
                2'b01:   r = 10'b0010101011;
                2'b10:   r = 10'b0101010100;
                default: r = 10'b1010101011;
            endcase
        end else if (cnt_in == 0 || nq1 == nq0) begin
            r = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_out = cnt_in + (q[8] ? nq1 - nq0 : nq0 - nq1);
        end else if ((cnt_in > 0 && nq1 > nq0) || (cnt_in < 0 && nq0 > nq1)) begin
            r = {1'b1, q[8], ~q[7:0]};
            cnt_out = cnt_in + 2 * int'(q[8]) + nq0 - nq1;
        end else begin
            r = {1'b0, q[8], q[7:0]};
            cnt_out = cnt_in - 2 * int'(!q[8]) + nq1 - nq0;
        end
        return r;
    endfunction

    task automatic send(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                        input logic [9:0] e);
        @(negedge clk);
        rst_n = 1'b1;
        de = d_e;
        din = d;
        {c1, c0} = c;
        sb.push_back('{cyc + 3, e, vid});
        vid++;
    endtask

    task automatic send_model(input logic d_e, input logic [7:0] d, input logic [1:0] c);
        logic [9:0] e;
        int nc;
        e = tmds_ref(d_e, d, c, mcnt, nc);
        mcnt = nc;
        send(d_e, d, c, e);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n = 1'b0;
            de = 1'($urandom);
            din = 8'($urandom);
            {c1, c0} = 2'($urandom);
            if (k == 0) sb.delete();
            sb.push_back('{cyc + 1, 10'h000, vid});
            vid++;
        end
        sb.push_back('{cyc + 2, 10'h354, vid});
        sb.push_back('{cyc + 3, 10'h354, vid + 1});
        vid += 2;
        mcnt = 0;
    endtask

    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                total++;
                if (dout !== e.exp) begin
                    bad++;
                    $display("FAIL dout vec=%0d got=%h want=%h", e.id, dout, e.exp);
                end
            end
        end
    end

    initial begin
        do_reset(4);
        send(1'b0, 8'hA5, 2'b00, 10'h354);
        send(1'b0, 8'h3C, 2'b00, 10'h354);
        send(1'b0, 8'h00, 2'b01, 10'h0AB);
        send(1'b0, 8'h00, 2'b10, 10'h154);
        send(1'b0, 8'h00, 2'b11, 10'h2AB);
        send(1'b0, 8'h00, 2'b00, 10'h354);
        send(1'b1, 8'h00, 2'b00, 10'h100);
        send(1'b1, 8'h00, 2'b00, 10'h3FF);
        send(1'b1, 8'h00, 2'b00, 10'h100);
        send(1'b0, 8'hFF, 2'b01, 10'h0AB);
        send(1'b1, 8'hFF, 2'b00, 10'h200);
        send(1'b1, 8'hFF, 2'b00, 10'h0FF);
        send(1'b0, 8'h00, 2'b00, 10'h354);
        send(1'b1, 8'h00, 2'b00, 10'h100);
        send(1'b0, 8'h00, 2'b00, 10'h354);
        send(1'b1, 8'h00, 2'b00, 10'h100);
        send(1'b0, 8'h00, 2'b10, 10'h154);
        send(1'b1, 8'h55, 2'b11, 10'h133);
        send(1'b1, 8'h55, 2'b00, 10'h133);
        send(1'b0, 8'h00, 2'b00, 10'h354);
        mcnt = 0;
        for (int k = 0; k < 6; k++) send_model(1'b1, 8'($urandom), 2'($urandom));
        do_reset(1);
        for (int k = 0; k < 5; k++) send_model(1'b1, 8'($urandom), 2'($urandom));
        for (int k = 0; k < 10000; k++)
            send_model($urandom_range(0, 7) != 0, 8'($urandom), 2'($urandom));
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
